user_digit_entry: RTL and testbench

Collects the player's guess one BCD digit at a time from the keypad front end and assembles it into a 16-bit packed word. Its output feeds the comparison stage against the generated random number. It produces a `done` pulse once all four digits are entered. It is armed by the game controller after the random digits have been shown, and it supports backspace and an inactivity timeout.

---
 rtl/user_digit_entry_pkg.sv | 20 ++
 rtl/entry_idle_timer.sv | 44 ++++
 rtl/user_digit_entry.sv | 121 ++++++++++++
 tb/tb_user_digit_entry.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/user_digit_entry_pkg.sv
// Shared game definitions: entry FSM states, BCD limits and guess word geometry.
// Also holds the helper that maps a digit slot to its bit position in the packed guess.
package user_digit_entry_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         DIGIT_W = 4;
  localparam int         GUESS_W = 16;

  // Slot 0 is the first digit entered and sits in the least significant nibble.
  function automatic int nibble_lsb(input logic [1:0] slot);
    return int'(slot) * DIGIT_W;
  endfunction

endpackage

// File: rtl/entry_idle_timer.sv
// Inactivity timer for guess entry: counts run cycles, restarts on clear.
// expired is combinational and only ever high for one cycle, because the owner leaves COLLECT on it.
module entry_idle_timer #(
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (at_last) begin
        cnt_d   = '0;
        expired = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/user_digit_entry.sv
// Assembles four BCD key presses into the packed guess word, with backspace and inactivity abort.
// done/timeout are registered one-cycle pulses; start always wins over key strobes.
module user_digit_entry
  import user_digit_entry_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_del,
  output logic [GUESS_W-1:0] user_int,
  output logic [2:0]         digit_count,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

  state_e             state_q, state_d;
  logic [GUESS_W-1:0] user_int_q, user_int_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  logic       in_collect;
  logic       digit_ok;
  logic       accept;
  logic       del_hit;
  logic       timer_clear;
  logic       timer_run;
  logic       expired;
  logic [1:0] add_slot;
  logic [1:0] del_slot;

  assign in_collect = (state_q == COLLECT);
  assign digit_ok   = key_valid && (key_digit <= BCD_MAX);
  assign del_hit    = in_collect && !start && key_del;
  assign accept     = in_collect && !start && !key_del && digit_ok && (cnt_q < FULL_CNT);
  assign add_slot   = cnt_q[1:0];
  assign del_slot   = 2'(cnt_q - 3'd1);

  // A backspace restarts the idle window even when there is nothing to erase.
  assign timer_clear = start || accept || del_hit;
  assign timer_run   = in_collect && !timer_clear;

  entry_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    user_int_d = user_int_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    if (start) begin
      state_d    = COLLECT;
      user_int_d = '0;
      cnt_d      = '0;
    end else if (in_collect) begin
      if (key_del) begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
          user_int_d[nibble_lsb(del_slot) +: DIGIT_W] = '0;
        end
      end else if (accept) begin
        user_int_d[nibble_lsb(add_slot) +: DIGIT_W] = key_digit;
        cnt_d = cnt_q + 3'd1;
        if (cnt_d == FULL_CNT) begin
          state_d = COMPLETE;
          done_d  = 1'b1;
        end
      end else if (expired) begin
        state_d    = IDLE;
        user_int_d = '0;
        cnt_d      = '0;
        timeout_d  = 1'b1;
      end
    end

    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      user_int_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      user_int_q <= user_int_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign user_int    = user_int_q;
  assign digit_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_user_digit_entry.sv
// Directed bench for user_digit_entry: vector table for entry/backspace/priority,
// hand sequences for inactivity timeout and asynchronous reset.
module tb_user_digit_entry;

  logic        clk;
  logic        rst;
  logic        start;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_del;
  logic [15:0] user_int;
  logic [2:0]  digit_count;
  logic        busy;
  logic        done;
  logic        timeout;

  int checks;
  int failures;

  user_digit_entry #(
    .NUM_DIGITS     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_del     (key_del),
    .user_int    (user_int),
    .digit_count (digit_count),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        kv;
    logic [3:0]  kd;
    logic        del;
    logic [15:0] ui;
    logic [2:0]  cnt;
    logic        bsy;
    logic        dn;
    logic        to;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic st, input logic kv, input logic [3:0] kd, input logic del,
                     input logic [15:0] ui, input logic [2:0] cnt,
                     input logic bsy, input logic dn, input logic to);
    vec_t v;
    v.st = st; v.kv = kv; v.kd = kd; v.del = del;
    v.ui = ui; v.cnt = cnt; v.bsy = bsy; v.dn = dn; v.to = to;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, return at the next negedge.
  task automatic apply(input logic st, input logic kv, input logic [3:0] kd, input logic del);
    start = st; key_valid = kv; key_digit = kd; key_del = del;
    @(negedge clk);
    start = 1'b0; key_valid = 1'b0; key_digit = 4'd0; key_del = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ui, input logic [2:0] cnt,
                         input logic bsy, input logic dn, input logic to);
    chk({tag, " user_int"},    user_int,           ui);
    chk({tag, " digit_count"}, 16'(digit_count),   16'(cnt));
    chk({tag, " busy"},        16'(busy),          16'(bsy));
    chk({tag, " done"},        16'(done),          16'(dn));
    chk({tag, " timeout"},     16'(timeout),       16'(to));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0; key_valid = 1'b0; key_digit = 4'd0; key_del = 1'b0;

    //   st kv kd    del  user_int  cnt busy done to
    add(1, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 4'h3, 0, 16'h0003, 1, 1, 0, 0);
    add(0, 1, 4'h7, 0, 16'h0073, 2, 1, 0, 0);
    add(0, 1, 4'hC, 0, 16'h0073, 2, 1, 0, 0);
    add(0, 1, 4'h1, 0, 16'h0173, 3, 1, 0, 0);
    add(0, 1, 4'h9, 0, 16'h9173, 4, 0, 1, 0);
    add(0, 0, 4'h0, 0, 16'h9173, 4, 0, 0, 0);
    add(1, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 4'h5, 0, 16'h0005, 1, 1, 0, 0);
    add(0, 1, 4'h2, 0, 16'h0025, 2, 1, 0, 0);
    add(0, 0, 4'h0, 1, 16'h0005, 1, 1, 0, 0);
    add(0, 1, 4'h8, 0, 16'h0085, 2, 1, 0, 0);
    add(0, 1, 4'h0, 0, 16'h0085, 3, 1, 0, 0);
    add(0, 1, 4'h4, 0, 16'h4085, 4, 0, 1, 0);
    add(0, 0, 4'h0, 0, 16'h4085, 4, 0, 0, 0);
    add(1, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 4'h7, 0, 16'h0007, 1, 1, 0, 0);
    add(0, 1, 4'h5, 1, 16'h0000, 0, 1, 0, 0);
    add(0, 0, 4'h0, 1, 16'h0000, 0, 1, 0, 0);
    add(1, 1, 4'h3, 0, 16'h0000, 0, 1, 0, 0);
    add(0, 1, 4'h4, 0, 16'h0004, 1, 1, 0, 0);
    add(0, 1, 4'h3, 0, 16'h0034, 2, 1, 0, 0);
    add(0, 1, 4'h2, 0, 16'h0234, 3, 1, 0, 0);
    add(0, 1, 4'h1, 0, 16'h1234, 4, 0, 1, 0);
    add(0, 1, 4'h5, 0, 16'h1234, 4, 0, 0, 0);
    add(0, 0, 4'h0, 1, 16'h1234, 4, 0, 0, 0);
    add(1, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 0);

    #3;
    chk_all("reset", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].st, vecs[i].kv, vecs[i].kd, vecs[i].del);
      chk_all($sformatf("row%0d", i), vecs[i].ui, vecs[i].cnt, vecs[i].bsy, vecs[i].dn, vecs[i].to);
    end

    // Timeout: one digit, then 8 cycles without an accepted key (an illegal key does not restart the window).
    apply(0, 1, 4'h6, 0);
    chk_all("to_key6", 16'h0006, 1, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) apply(0, 1, 4'hC, 0);
      else        apply(0, 0, 4'h0, 0);
      if (i < 8) chk_all($sformatf("to_idle%0d", i), 16'h0006, 1, 1, 0, 0);
      else       chk_all("to_expire", 16'h0000, 0, 0, 0, 1);
    end
    apply(0, 0, 4'h0, 0);
    chk_all("to_after", 16'h0000, 0, 0, 0, 0);
    apply(0, 1, 4'h5, 0);
    chk_all("to_key_ignored", 16'h0000, 0, 0, 0, 0);

    // Async reset mid-entry, between clock edges.
    apply(1, 0, 4'h0, 0);
    apply(0, 1, 4'h2, 0);
    apply(0, 1, 4'h5, 0);
    chk_all("ar_pre", 16'h0052, 2, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk_all("ar_mid", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset while the done pulse is in flight.
    apply(1, 0, 4'h0, 0);
    apply(0, 1, 4'h1, 0);
    apply(0, 1, 4'h2, 0);
    apply(0, 1, 4'h3, 0);
    key_valid = 1'b1; key_digit = 4'h4;
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_digit = 4'h0;
    chk_all("ar_done_pre", 16'h4321, 4, 0, 1, 0);
    rst = 1'b1;
    #1 chk_all("ar_done_kill", 16'h0000, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    apply(0, 1, 4'h7, 0);
    chk_all("ar_idle_after", 16'h0000, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
